// File: rtl/load_store_unit.sv
// Byte-addressed load/store unit in front of a word-wide, one-cycle-latency memory.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses into two memory transactions.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ST1  = 3'd1;
    localparam logic [2:0] LD1  = 3'd3;
    localparam logic [2:0] LD1C = 3'd4;
    localparam logic [2:0] RESP = 3'd6;
`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam logic [2:0] ST2  = 3'd2;
    localparam logic [2:0] LD2C = 3'd5;
`endif

    logic [2:0]  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] base_q;
    logic [4:0]  shamt;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [31:0] word0_q, word0_d;
    logic [31:0] next_q;
    logic        cross_q;
`else
    logic        req_cross;
`endif

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   crosses = 1'b0;
            2'b01:   crosses = (off == 2'b11);
            default: crosses = (off != 2'b00);
        endcase
    endfunction

    function automatic logic legal(input logic st, input logic [2:0] f3);
        if (st)
            legal = !f3[2] && (f3[1:0] != 2'b11);
        else
            legal = (f3[1:0] != 2'b11) && (f3 != 3'b110);
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
            3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
            3'b100:  extend = {24'h000000, raw[7:0]};
            3'b101:  extend = {16'h0000, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    assign base_q = {addr_q[31:2], 2'b00};
    assign shamt  = {addr_q[1:0], 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
    assign next_q  = base_q + 32'd4;
    assign cross_q = crosses(addr_q[1:0], funct3_q);
`else
    assign req_cross = crosses(req_addr[1:0], req_funct3);
`endif

    // resp_rdata is only rewritten on the transition into RESP, so it holds between responses
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
        word0_d  = word0_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = 1'b0;
                    if (!legal(req_store, req_funct3)) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
`ifndef LSU_MISALIGNED_SPLIT_EN
                    else if (req_cross) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
`endif
                    else if (req_store) begin
                        state_d = ST1;
                    end else begin
                        state_d = LD1;
                    end
                end
            end
            ST1: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (cross_q) begin
                    state_d = ST2;
                end else begin
                    state_d = RESP;
                    rdata_d = '0;
                end
`else
                state_d = RESP;
                rdata_d = '0;
`endif
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            ST2: begin
                state_d = RESP;
                rdata_d = '0;
            end
`endif
            LD1: begin
                state_d = LD1C;
            end
            LD1C: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (cross_q) begin
                    word0_d = mem_rdata;
                    state_d = LD2C;
                end else begin
                    rdata_d = extend(funct3_q, mem_rdata >> shamt);
                    state_d = RESP;
                end
`else
                rdata_d = extend(funct3_q, mem_rdata >> shamt);
                state_d = RESP;
`endif
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            LD2C: begin
                // Second word sits above the first; shifting the pair aligns byte A to lane 0
                rdata_d = extend(funct3_q, 32'({mem_rdata, word0_q} >> shamt));
                state_d = RESP;
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            word0_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
            word0_q  <= word0_d;
`endif
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = rdata_q;
        mem_raddr  = '0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_we     = '0;
        case (state_q)
            ST1: begin
                mem_waddr = base_q;
                mem_wdata = wdata_q << shamt;
                mem_we    = size_mask(funct3_q) << addr_q[1:0];
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            ST2: begin
                // Lanes that overflowed the first word land at the bottom of the next one
                mem_waddr = next_q;
                mem_wdata = wdata_q >> (6'd32 - {1'b0, shamt});
                mem_we    = 4'(({4'b0000, size_mask(funct3_q)} << addr_q[1:0]) >> 4);
            end
`endif
            LD1: begin
                mem_raddr = base_q;
            end
            LD1C: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (cross_q)
                    mem_raddr = next_q;
`endif
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed spec scenarios plus random traffic against a byte-level model.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_clear;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [3:0]  we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
    } cyc_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          g_lat;
    logic [31:0] g_rd;
    logic        g_err;
    int          g_wecyc;
    int          g_misalign = 0;
    cyc_t        log_q[$];
    bit   [7:0]  rmem [bit [31:0]];
    logic [7:0]  dmem [4096];

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: lane-enabled writes, read data one cycle after the address
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int j = 0; j < 4096; j++) dmem[j] <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mem_we[i] === 1'b1) dmem[12'(mem_waddr + 32'(i))] <= mem_wdata[8*i +: 8];
        end
        mem_rdata <= {dmem[12'(mem_raddr + 32'd3)], dmem[12'(mem_raddr + 32'd2)],
                      dmem[12'(mem_raddr + 32'd1)], dmem[12'(mem_raddr)]};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int unsigned sz(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit legal(input logic st, input logic [2:0] f3);
        if (st) return f3 < 3'd3;
        return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    function automatic bit crosses(input logic [31:0] a, input logic [2:0] f3);
        return (a % 4) + sz(f3) > 4;
    endfunction

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int unsigned n;
        v = '0;
        n = sz(f3);
        for (int unsigned i = 0; i < n; i++) v |= 32'(rbyte(a + i)) << (8 * i);
        if (!f3[2] && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        for (int unsigned i = 0; i < sz(f3); i++) rmem[a + i] = d[8*i +: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then log memory-side activity each cycle until the response
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        int   guard;
        cyc_t c;
        log_q.delete();
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        g_lat = 0;
        g_rd  = 'x;
        g_err = 1'bx;
        for (int k = 1; k <= 12; k++) begin
            c.we    = mem_we;
            c.waddr = mem_waddr;
            c.wdata = mem_wdata;
            c.raddr = mem_raddr;
            log_q.push_back(c);
            if (mem_waddr[1:0] != 2'b00 || mem_raddr[1:0] != 2'b00) g_misalign++;
            if (resp_valid === 1'b1) begin
                g_lat = k;
                g_rd  = resp_rdata;
                g_err = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_model(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        bit cr;
        bit e;
        int exp_lat;
        int exp_we;
        logic [31:0] exp_rd;
        cr = crosses(a, f3);
        e  = !legal(st, f3) || (cr && !SPLIT);
        exp_rd = (e || st) ? 32'd0 : ref_load(a, f3);
        do_req(tag, st, f3, a, d);
        g_wecyc = 0;
        foreach (log_q[i]) if (log_q[i].we != 4'b0000) g_wecyc++;
        exp_lat = e ? 1 : (st ? (cr ? 3 : 2) : (cr ? 4 : 3));
        exp_we  = (e || !st) ? 0 : (cr ? 2 : 1);
        check({tag, ".lat"}, 32'(g_lat), 32'(exp_lat));
        check({tag, ".err"}, 32'(g_err), 32'(e));
        check({tag, ".rdata"}, g_rd, exp_rd);
        check({tag, ".we_cycles"}, 32'(g_wecyc), 32'(exp_we));
        if (st && !e) model_store(a, f3, d);
    endtask

    initial begin
        logic [31:0] w;
        logic [4:0]  rdy_v;
        logic [4:0]  rv_v;
        int          cnt;

        reset      = 1'b1;
        mem_clear  = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        @(posedge clk); #1;
        mem_clear = 1'b0;
        @(posedge clk); #1;

        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_raddr", mem_raddr, 32'd0);
        check("rst.mem_waddr", mem_waddr, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        run_model("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        check("sw_100.waddr", log_q[0].waddr, 32'h100);
        check("sw_100.we", 32'(log_q[0].we), 32'b1111);
        check("sw_100.wdata", log_q[0].wdata, 32'hDEADBEEF);
        check("sw_100.lat2", 32'(g_lat), 32'd2);

        run_model("sb_103", 1'b1, 3'b000, 32'h103, 32'h000000A5);
        w = log_q[0].wdata;
        check("sb_103.we", 32'(log_q[0].we), 32'b1000);
        check("sb_103.wdata", 32'(w[31:24]), 32'hA5);
        run_model("lb_103", 1'b0, 3'b000, 32'h103, 32'h0);
        check("lb_103.value", g_rd, 32'hFFFFFFA5);
        check("lb_103.lat3", 32'(g_lat), 32'd3);
        run_model("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0);
        check("lbu_103.value", g_rd, 32'h000000A5);
        @(posedge clk); #1;
        check("rdata_hold", resp_rdata, 32'h000000A5);
        check("idle.resp_valid", 32'(resp_valid), 32'd0);

        run_model("lh_101", 1'b0, 3'b001, 32'h101, 32'h0);
        check("lh_101.value", g_rd, 32'hFFFFADBE);
        run_model("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0);
        check("lhu_102.value", g_rd, 32'h0000A5AD);

`ifdef LSU_MISALIGNED_SPLIT_EN
        run_model("sw_202", 1'b1, 3'b010, 32'h202, 32'h11223344);
        w = log_q[0].wdata;
        check("sw_202.st1.waddr", log_q[0].waddr, 32'h200);
        check("sw_202.st1.we", 32'(log_q[0].we), 32'b1100);
        check("sw_202.st1.wdata", 32'(w[31:16]), 32'h3344);
        w = log_q[1].wdata;
        check("sw_202.st2.waddr", log_q[1].waddr, 32'h204);
        check("sw_202.st2.we", 32'(log_q[1].we), 32'b0011);
        check("sw_202.st2.wdata", 32'(w[15:0]), 32'h1122);
        run_model("lw_202", 1'b0, 3'b010, 32'h202, 32'h0);
        check("lw_202.value", g_rd, 32'h11223344);
        check("lw_202.lat4", 32'(g_lat), 32'd4);
        check("lw_202.raddr1", log_q[0].raddr, 32'h200);
        check("lw_202.raddr2", log_q[1].raddr, 32'h204);
        run_model("sh_wrap", 1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF);
        check("sh_wrap.waddr2", log_q[1].waddr, 32'h0);
        run_model("lh_wrap", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
        check("lh_wrap.raddr2", log_q[1].raddr, 32'h0);
        check("lh_wrap.value", g_rd, 32'hFFFFBEEF);
`else
        run_model("lh_303", 1'b0, 3'b001, 32'h303, 32'h0);
        check("lh_303.lat1", 32'(g_lat), 32'd1);
        check("lh_303.err", 32'(g_err), 32'd1);
        check("lh_303.rdata", g_rd, 32'd0);
        check("lh_303.we", 32'(g_wecyc), 32'd0);
        run_model("sw_202", 1'b1, 3'b010, 32'h202, 32'h11223344);
        check("sw_202.err", 32'(g_err), 32'd1);
`endif

        run_model("st_ill", 1'b1, 3'b100, 32'h100, 32'h12345678);
        check("st_ill.err", 32'(g_err), 32'd1);
        check("st_ill.lat1", 32'(g_lat), 32'd1);
        run_model("ld_ill", 1'b0, 3'b011, 32'h100, 32'h0);
        check("ld_ill.err", 32'(g_err), 32'd1);

        // Reset while the load sits in LD1C
        @(posedge clk); #1;
        check("rst_mid.idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid.ready", 32'(req_ready), 32'd1);
        check("rst_mid.resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mid.mem_we", 32'(mem_we), 32'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (6) begin
            if (resp_valid === 1'b1 || mem_we != 4'b0000) cnt++;
            @(posedge clk); #1;
        end
        check("rst_mid.quiet", 32'(cnt), 32'd0);

        // Back-to-back stores with req_valid held high
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h140;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            rdy_v[k] = req_ready;
            rv_v[k]  = resp_valid;
            if (k == 4) req_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("b2b.ready", 32'(rdy_v), 32'(5'b00100));
        check("b2b.resp_valid", 32'(rv_v), 32'(5'b10010));
        model_store(32'h140, 3'b010, 32'hCAFEF00D);
        run_model("lw_140", 1'b0, 3'b010, 32'h140, 32'h0);

        for (int n = 0; n < 150; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 1) == 1) ? 32'h400 : 32'hFFFFFFF0;
            a  = a + 32'($urandom_range(0, 31));
            run_model("rand", st, f3, a, $urandom());
        end

        check("addr_aligned", 32'(g_misalign), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
